// File: rtl/div_operand_feeder.sv
// Buffers host operand pairs in a FIFO and issues them one at a time to the 10/3 divider,
// returning each 20-bit result (or a timeout error marker) to the host with a sequence tag.
module div_operand_feeder #(
  parameter int DEPTH   = 4,
  parameter int TAG_W   = 4,
  parameter int TIMEOUT = 64
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_src_valid,
  input  logic [9:0]       i_src_data_1,
  input  logic [2:0]       i_src_data_2,
  output logic             o_src_ready,
  output logic             o_dv_in_valid,
  output logic [9:0]       o_dv_in_data_1,
  output logic [2:0]       o_dv_in_data_2,
  input  logic             i_dv_out_valid,
  input  logic [19:0]      i_dv_out_data,
  output logic             o_res_valid,
  output logic [19:0]      o_res_data,
  output logic [TAG_W-1:0] o_res_tag,
  output logic             o_res_err,
  input  logic             i_res_ready,
  output logic             o_busy
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT_RES, S_WAIT_IDLE} state_t;
  state_t r_state;
  state_t w_state_nxt;

  logic [12:0]      r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic [TW-1:0]    r_timer;
  logic [TAG_W-1:0] r_tag;
  logic [9:0]       r_op1;
  logic [2:0]       r_op2;
  logic             r_res_valid;
  logic [19:0]      r_res_data;
  logic [TAG_W-1:0] r_res_tag;
  logic             r_res_err;

  logic w_push;
  logic w_pop;
  logic w_got;
  logic w_tmo;

  assign o_src_ready = !i_rst && (r_count < DEPTH_C);
  assign w_push      = i_src_valid && o_src_ready;
  // A pending result blocks the next issue, keeping a single operation in flight.
  assign w_pop       = (r_state == S_IDLE) && (r_count != '0) && !r_res_valid;
  assign w_got       = (r_state == S_WAIT_RES) && i_dv_out_valid;
  assign w_tmo       = (r_state == S_WAIT_RES) && !i_dv_out_valid && (r_timer == TMO_LAST);

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:      if (w_pop) w_state_nxt = S_ISSUE;
      S_ISSUE:     w_state_nxt = S_WAIT_RES;
      S_WAIT_RES: begin
        if (i_dv_out_valid)             w_state_nxt = S_WAIT_IDLE;
        else if (r_timer == TMO_LAST)   w_state_nxt = S_IDLE;
      end
      // The divider holds out_valid for several cycles; wait it out so it is not recaptured.
      S_WAIT_IDLE: if (!i_dv_out_valid) w_state_nxt = S_IDLE;
      default:     w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= {i_src_data_1, i_src_data_2};
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_timer     <= '0;
      r_tag       <= '0;
      r_op1       <= '0;
      r_op2       <= '0;
      r_res_valid <= 1'b0;
      r_res_data  <= '0;
      r_res_tag   <= '0;
      r_res_err   <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase

      if (w_pop) {r_op1, r_op2} <= r_mem[r_rd_ptr];

      if (r_state == S_ISSUE)         r_timer <= '0;
      else if (r_state == S_WAIT_RES) r_timer <= r_timer + 1'b1;

      if (w_got || w_tmo) begin
        r_res_valid <= 1'b1;
        r_res_data  <= w_got ? i_dv_out_data : 20'hFFFFF;
        r_res_tag   <= r_tag;
        r_res_err   <= w_tmo;
        r_tag       <= r_tag + 1'b1;
      end else if (r_res_valid && i_res_ready) begin
        r_res_valid <= 1'b0;
      end
    end
  end

  assign o_dv_in_valid  = !i_rst && (r_state == S_ISSUE);
  assign o_dv_in_data_1 = i_rst ? '0 : r_op1;
  assign o_dv_in_data_2 = i_rst ? '0 : r_op2;
  assign o_res_valid    = !i_rst && r_res_valid;
  assign o_res_data     = i_rst ? '0 : r_res_data;
  assign o_res_tag      = i_rst ? '0 : r_res_tag;
  assign o_res_err      = !i_rst && r_res_err;
  assign o_busy         = !i_rst && ((r_state != S_IDLE) || (r_count != '0));

endmodule

// File: tb/tb_div_operand_feeder.sv
// Scoreboard bench for div_operand_feeder with a stub divider (quotient/remainder result).
module tb_div_operand_feeder;
  localparam int TAG_W = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst = 1'b1;
  logic             src_valid = 1'b0;
  logic [9:0]       src_d1 = '0;
  logic [2:0]       src_d2 = '0;
  logic             src_ready;
  logic             dv_in_valid;
  logic [9:0]       dv_in_d1;
  logic [2:0]       dv_in_d2;
  logic             dv_out_valid = 1'b0;
  logic [19:0]      dv_out_data = '0;
  logic             res_valid;
  logic [19:0]      res_data;
  logic [TAG_W-1:0] res_tag;
  logic             res_err;
  logic             res_ready = 1'b1;
  logic             busy;

  div_operand_feeder #(.DEPTH(4), .TAG_W(TAG_W), .TIMEOUT(64)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_src_valid(src_valid), .i_src_data_1(src_d1), .i_src_data_2(src_d2), .o_src_ready(src_ready),
    .o_dv_in_valid(dv_in_valid), .o_dv_in_data_1(dv_in_d1), .o_dv_in_data_2(dv_in_d2),
    .i_dv_out_valid(dv_out_valid), .i_dv_out_data(dv_out_data),
    .o_res_valid(res_valid), .o_res_data(res_data), .o_res_tag(res_tag), .o_res_err(res_err),
    .i_res_ready(res_ready), .o_busy(busy)
  );

  // Directed vectors: result = {quotient, remainder}; divide-by-zero gives {3FF, dividend}.
  logic [9:0]  vec_a   [8] = '{10'd5, 10'd100, 10'd1023, 10'd9, 10'd77, 10'd512, 10'd3, 10'd600};
  logic [2:0]  vec_b   [8] = '{3'd1, 3'd7, 3'd3, 3'd0, 3'd5, 3'd6, 3'd7, 3'd2};
  logic [19:0] vec_exp [8] = '{20'h01400, 20'h03802, 20'h55400, 20'hFFC09,
                               20'h03C02, 20'h15402, 20'h00003, 20'h4B000};

  // Stub divider: latches on in_valid, out_valid high for two cycles a few cycles later.
  logic       stub_mute = 1'b0;
  logic [9:0] st_a = '0;
  logic [2:0] st_b = '0;
  int         st_cnt = 0;
  always @(posedge clk) begin
    if (rst) begin
      st_cnt <= 0; dv_out_valid <= 1'b0; dv_out_data <= '0;
    end else if (st_cnt == 0) begin
      dv_out_valid <= 1'b0;
      if (dv_in_valid && !stub_mute) begin
        st_a <= dv_in_d1; st_b <= dv_in_d2; st_cnt <= 1;
      end
    end else if (st_cnt == 5) begin
      dv_out_valid <= 1'b0; st_cnt <= 0;
    end else begin
      st_cnt <= st_cnt + 1;
      if (st_cnt >= 3) begin
        dv_out_valid <= 1'b1;
        dv_out_data  <= (st_b == 3'd0) ? {10'h3FF, st_a} : {st_a / 10'(st_b), st_a % 10'(st_b)};
      end
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [19:0]      data;
    logic [TAG_W-1:0] tag;
    logic             err;
  } exp_t;
  exp_t             sb_q[$];
  logic [TAG_W-1:0] exp_tag = '0;
  int               checks = 0;
  int               errors = 0;
  int               n_results = 0;
  logic [TAG_W-1:0] last_tag = '0;
  logic             prev_ivld = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  // Monitor: samples mid low-phase, after the stimulus has settled for the coming edge.
  always @(negedge clk) begin
    exp_t e;
    #1;
    if (!rst) begin
      if (dv_in_valid) chk("dv_in_valid_one_cycle", {31'd0, prev_ivld}, 32'd0);
      prev_ivld = dv_in_valid;
      if (res_valid && res_ready) begin
        if (sb_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_result: got data %0h tag %0h, required none", res_data, res_tag);
        end else begin
          e = sb_q.pop_front();
          chk("res_data", {12'd0, res_data}, {12'd0, e.data});
          chk("res_tag", 32'(res_tag), 32'(e.tag));
          chk("res_err", {31'd0, res_err}, {31'd0, e.err});
          n_results++;
          last_tag = res_tag;
        end
      end
    end else begin
      prev_ivld = 1'b0;
    end
  end

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic drive_push(input int idx, input bit tmo);
    exp_t e;
    e.data = tmo ? 20'hFFFFF : vec_exp[idx];
    e.tag  = exp_tag;
    e.err  = tmo;
    sb_q.push_back(e);
    exp_tag = exp_tag + 1'b1;
    src_valid = 1'b1; src_d1 = vec_a[idx]; src_d2 = vec_b[idx];
    for (int i = 0; i < 300; i++) begin
      if (src_ready) begin
        @(posedge clk); @(negedge clk);
        src_valid = 1'b0;
        return;
      end
      @(negedge clk);
    end
    checks++; errors++;
    $display("FAIL push_accept: got no src_ready, required acceptance of vector %0d", idx);
    src_valid = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (sb_q.size() == 0 && !busy && !res_valid) return;
      @(negedge clk);
    end
    checks++; errors++;
    $display("FAIL drain: got %0d results outstanding, required 0", sb_q.size());
  endtask

  task automatic wait_sig(input string name, input int which, input int budget);
    for (int i = 0; i < budget; i++) begin
      if ((which == 0 && dv_in_valid) || (which == 1 && res_valid)) return;
      @(negedge clk);
    end
    checks++; errors++;
    $display("FAIL %s: got no assertion within %0d cycles, required assertion", name, budget);
  endtask

  initial begin
    int k0;
    int k1;
    int bad;
    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_src_ready", {31'd0, src_ready}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_res_valid", {31'd0, res_valid}, 32'd0);
    chk("rst_dv_in", {19'd0, dv_in_valid, dv_in_d1, dv_in_d2}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_src_ready", {31'd0, src_ready}, 32'd1);
    chk("post_rst_busy", {31'd0, busy}, 32'd0);

    // Single op: two-cycle push-to-issue, one-cycle pulse, operands held afterwards
    drive_push(0, 1'b0);
    chk("issue_lat_t1", {31'd0, dv_in_valid}, 32'd0);
    @(negedge clk);
    chk("issue_pulse", {31'd0, dv_in_valid}, 32'd1);
    chk("issue_data", {19'd0, dv_in_d1, dv_in_d2}, {19'd0, 10'd5, 3'd1});
    @(negedge clk);
    chk("issue_end", {31'd0, dv_in_valid}, 32'd0);
    chk("wait_data_held", {19'd0, dv_in_d1, dv_in_d2}, {19'd0, 10'd5, 3'd1});
    chk("busy_in_flight", {31'd0, busy}, 32'd1);
    wait_sig("single_res", 1, 100);
    @(negedge clk);
    chk("res_valid_one_cycle", {31'd0, res_valid}, 32'd0);
    wait_drain(100);

    // Backpressure + burst fill
    res_ready = 1'b0;
    drive_push(1, 1'b0);
    wait_sig("bp_first_res", 1, 100);
    for (int i = 2; i < 6; i++) drive_push(i, 1'b0);
    chk("burst_full_ready", {31'd0, src_ready}, 32'd0);
    drive_push_hold: begin
      exp_t e;
      e.data = vec_exp[6]; e.tag = exp_tag; e.err = 1'b0;
      sb_q.push_back(e);
      exp_tag = exp_tag + 1'b1;
      src_valid = 1'b1; src_d1 = vec_a[6]; src_d2 = vec_b[6];
    end
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      if (!res_valid || res_data !== sb_q[0].data || res_tag !== sb_q[0].tag || res_err !== 1'b0 ||
          dv_in_valid || src_ready) bad++;
      @(negedge clk);
    end
    chk("bp_stable_cycles_bad", 32'(bad), 32'd0);
    res_ready = 1'b1;
    @(negedge clk);
    chk("bp_no_issue_at_consume", {31'd0, dv_in_valid}, 32'd0);
    @(negedge clk);
    chk("bp_issue_after_release", {31'd0, dv_in_valid}, 32'd1);
    chk("bp_slot_freed", {31'd0, src_ready}, 32'd1);
    @(posedge clk); @(negedge clk);
    src_valid = 1'b0;
    wait_drain(500);

    // Timeout, then the next operand issues normally
    stub_mute = 1'b1;
    drive_push(7, 1'b1);
    wait_sig("tmo_issue", 0, 20);
    k0 = cyc;
    drive_push(4, 1'b0);
    wait_sig("tmo_res", 1, 200);
    k1 = cyc;
    stub_mute = 1'b0;
    chk("tmo_latency", 32'(k1 - k0), 32'd65);
    @(negedge clk);
    wait_sig("tmo_next_issue", 0, 20);
    chk("tmo_next_issue_lat", 32'(cyc - k1), 32'd2);
    wait_drain(200);

    // Tag wrap: 17th result since reset carries tag 0
    for (int i = 0; i < 8; i++) drive_push(i, 1'b0);
    wait_drain(1000);
    chk("wrap_count", 32'(n_results), 32'd17);
    chk("wrap_tag", 32'(last_tag), 32'd0);

    // Reset during WAIT_RES with three operands queued
    for (int i = 0; i < 4; i++) drive_push(i + 2, 1'b0);
    rst = 1'b1;
    sb_q.delete();
    exp_tag = '0;
    n_results = 0;
    @(negedge clk);
    chk("midrst_src_ready", {31'd0, src_ready}, 32'd0);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_res_valid", {31'd0, res_valid}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("after_rst_busy", {31'd0, busy}, 32'd0);
    chk("after_rst_ready", {31'd0, src_ready}, 32'd1);
    drive_push(2, 1'b0);
    wait_drain(200);
    chk("after_rst_results", 32'(n_results), 32'd1);
    chk("after_rst_tag", 32'(last_tag), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
